// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared FSM encoding and width helpers for the uart_tx arbiter
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_WAIT_HI = 2'd3
  } uarb_state_e;

  function automatic int uarb_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter must hold BUSY_TIMEOUT itself because it saturates there.
  function automatic int uarb_cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - producer/uart_tx handshake bundle around the arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ack;
  logic               utx_ready;
  logic [7:0]         utx_data;
  logic               utx_strobe;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic               err_timeout;

  modport slave (
    input  req_valid, req_data, req_last, utx_ready,
    output req_ack, utx_data, utx_strobe, grant, busy, err_timeout
  );

  modport master (
    output req_valid, req_data, req_last, utx_ready,
    input  req_ack, utx_data, utx_strobe, grant, busy, err_timeout
  );
endinterface

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin picker: first eligible valid at or after ptr
module uart_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = uarb_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [N_REQ-1:0] mask,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [IW-1:0]    win_idx,
  output logic             any
);

  int c;

  // Scan from the farthest offset down so the nearest eligible requester wins last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    any     = 1'b0;
    c       = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = int'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (valid[c] && mask[c]) begin
        win_oh    = '0;
        win_oh[c] = 1'b1;
        win_idx   = IW'(c);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart_tx among N_REQ byte producers
// Optional UARB_LOCK_EN: keep the grant on one requester until it sends a byte with req_last=1.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic              mclk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = uarb_idx_w(N_REQ);
  localparam int CW = uarb_cnt_w(BUSY_TIMEOUT);

  uarb_state_e      state, state_d;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    cnt, cnt_d;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] win_oh;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic             take;
  logic             set_err;

`ifdef UARB_LOCK_EN
  logic          lock_active;
  logic [IW-1:0] lock_idx;

  always_comb begin
    elig = '1;
    if (lock_active) elig = N_REQ'(1) << lock_idx;
  end
`else
  logic unused_last;
  assign unused_last = ^bus.req_last;
  assign elig        = '1;
`endif

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid   (bus.req_valid),
    .mask    (elig),
    .ptr     (rr_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any     (win_any)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    take    = 1'b0;
    set_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.utx_ready && win_any) begin
          take    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT_LO;
        cnt_d   = '0;
      end
      ST_WAIT_LO: begin
        if (!bus.utx_ready) begin
          state_d = ST_WAIT_HI;
        end else if (cnt == CW'(BUSY_TIMEOUT)) begin
          set_err = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_WAIT_HI: begin
        // A frame at low baud can be long, so this wait is unbounded.
        if (bus.utx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      rr_ptr          <= '0;
      bus.req_ack     <= '0;
      bus.utx_strobe  <= 1'b0;
      bus.utx_data    <= 8'h00;
      bus.grant       <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      bus.utx_strobe  <= take;
      bus.req_ack     <= take ? win_oh : '0;
      bus.err_timeout <= bus.err_timeout | set_err;
      if (take) begin
        bus.utx_data <= bus.req_data[8*int'(win_idx) +: 8];
        bus.grant    <= win_oh;
        rr_ptr       <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

`ifdef UARB_LOCK_EN
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (take) begin
      lock_active <= !bus.req_last[win_idx];
      lock_idx    <= win_idx;
    end
  end
`endif

  assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter with a simple uart_tx ready model
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int FRAME = 20;

  logic mclk = 1'b0;
  logic reset_n;
  always #5 mclk = ~mclk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .mclk    (mclk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  bit ignore_strobe = 1'b0;
  int frame_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: ready drops in the strobe cycle, returns after a 10-bit frame.
  initial begin
    bus.utx_ready = 1'b1;
    forever begin
      @(negedge mclk);
      if (!ignore_strobe && bus.utx_strobe === 1'b1) begin
        bus.utx_ready = 1'b0;
        frame_cnt     = FRAME;
      end else if (frame_cnt > 0) begin
        frame_cnt--;
        if (frame_cnt == 0) bus.utx_ready = 1'b1;
      end
    end
  end

  task automatic wait_strobe(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge mclk);
      #1;
      if (bus.utx_strobe === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, "_rdy"}, 32'(bus.utx_ready), 32'd1);
      chk({tag, "_ackg"}, 32'(bus.req_ack), 32'(bus.grant));
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge mclk);
      #1;
      if (bus.busy === 1'b0 && bus.utx_ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, 32'(seen), 32'd1);
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    bus.req_data[8*i +: 8] = v;
  endtask

  logic [3:0] exp_g [3];
  logic [7:0] exp_d [3];
  int n;

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_last  = 4'hF;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));

    for (int i = 0; i < 4; i++) begin
      @(posedge mclk);
      #1;
      chk("rst_out", 32'({bus.req_ack, bus.utx_strobe, bus.utx_data, bus.grant,
                          bus.busy, bus.err_timeout}), 32'd0);
    end
    reset_n = 1'b1;

    for (int k = 0; k < 6; k++) begin
      wait_strobe("fair", 60);
      chk("fair_grant", 32'(bus.grant), 32'(4'b0001 << (k % 4)));
      chk("fair_data", 32'(bus.utx_data), 32'(8'hA0 + 8'(k % 4)));
      @(posedge mclk);
      #1;
      chk("fair_pulse", 32'({bus.utx_strobe, bus.req_ack}), 32'd0);
    end
    bus.req_valid = 4'h0;
    wait_idle("fair", 60);

    set_data(2, 8'h41);
    bus.req_valid = 4'b0100;
    wait_strobe("single", 20);
    chk("single_grant", 32'(bus.grant), 32'b0100);
    chk("single_ack", 32'(bus.req_ack), 32'b0100);
    chk("single_data", 32'(bus.utx_data), 32'h41);
    bus.req_valid = 4'h0;
    repeat (5) @(posedge mclk);
    #1;
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_rdylo", 32'(bus.utx_ready), 32'd0);
    wait_idle("single", 60);
    chk("single_hold", 32'(bus.utx_data), 32'h41);

    ignore_strobe = 1'b1;
    set_data(0, 8'h55);
    bus.req_valid = 4'b0001;
    wait_strobe("to", 20);
    bus.req_valid = 4'h0;
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < 100) begin
      @(posedge mclk);
      #1;
      n++;
    end
    chk("to_cycles", 32'(n), 32'(TO + 2));
    chk("to_idle", 32'(bus.busy), 32'd0);
    ignore_strobe = 1'b0;
    set_data(3, 8'h66);
    bus.req_valid = 4'b1000;
    wait_strobe("to_next", 20);
    chk("to_next_grant", 32'(bus.grant), 32'b1000);
    chk("to_next_data", 32'(bus.utx_data), 32'h66);
    chk("to_sticky", 32'(bus.err_timeout), 32'd1);
    bus.req_valid = 4'h0;
    wait_idle("to", 60);

    set_data(1, 8'h77);
    bus.req_valid = 4'b0010;
    wait_strobe("r6", 20);
    repeat (4) @(posedge mclk);
    #1;
    chk("r6_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    @(posedge mclk);
    #1;
    reset_n = 1'b1;
    chk("r6_rst", 32'({bus.busy, bus.utx_strobe, bus.err_timeout}), 32'd0);
    chk("r6_rdylo", 32'(bus.utx_ready), 32'd0);
    wait_strobe("r6_resend", 60);
    chk("r6_grant", 32'(bus.grant), 32'b0010);
    chk("r6_data", 32'(bus.utx_data), 32'h77);
    bus.req_valid = 4'h0;
    wait_idle("r6", 60);

    set_data(0, 8'h30);
    bus.req_valid = 4'b0001;
    wait_strobe("pre", 20);
    chk("pre_grant", 32'(bus.grant), 32'b0001);
    bus.req_valid = 4'h0;
    wait_idle("pre", 60);

`ifdef UARB_LOCK_EN
    exp_g = '{4'b0010, 4'b0010, 4'b0001};
    exp_d = '{8'h41, 8'h42, 8'h30};
`else
    exp_g = '{4'b0010, 4'b0001, 4'b0010};
    exp_d = '{8'h41, 8'h30, 8'h42};
`endif
    set_data(1, 8'h41);
    bus.req_last  = 4'b0001;
    bus.req_valid = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      wait_strobe("lock", 60);
      chk("lock_grant", 32'(bus.grant), 32'(exp_g[k]));
      chk("lock_data", 32'(bus.utx_data), 32'(exp_d[k]));
      if (exp_g[k] == 4'b0010 && exp_d[k] == 8'h41) begin
        set_data(1, 8'h42);
        bus.req_last[1] = 1'b1;
      end else if (exp_g[k] == 4'b0001) begin
        bus.req_valid[0] = 1'b0;
      end else begin
        bus.req_valid[1] = 1'b0;
      end
    end
    wait_idle("lock", 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
